// File: rtl/globals_cu_pkg.sv
// rtl/globals_cu_pkg.sv - shared CU constants, command line type and arbiter enums
package globals_cu_pkg;

    localparam int NUM_CU_CMD_REQ  = 4;
    localparam int CU_CMD_CREDITS  = 32;
    localparam int CU_CMD_CREDIT_W = 6;

    localparam logic [7:0] VERTEX_CONTROL_ID          = 8'h10;
    localparam logic [7:0] EDGE_DATA_READ_CONTROL_ID  = 8'h20;
    localparam logic [7:0] EDGE_DATA_WRITE_CONTROL_ID = 8'h30;
    localparam logic [7:0] PREFETCH_CONTROL_ID        = 8'h40;

    typedef enum logic [1:0] {
        REQ_VERTEX          = 2'd0,
        REQ_EDGE_DATA_READ  = 2'd1,
        REQ_EDGE_DATA_WRITE = 2'd2,
        REQ_PREFETCH        = 2'd3
    } cmd_arb_req_t;

    // Indexed by cmd_arb_req_t; element 0 is the least significant byte.
    localparam logic [NUM_CU_CMD_REQ-1:0][7:0] CMD_ARB_CONTROL_ID = {
        PREFETCH_CONTROL_ID,
        EDGE_DATA_WRITE_CONTROL_ID,
        EDGE_DATA_READ_CONTROL_ID,
        VERTEX_CONTROL_ID
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } cmd_arb_state_t;

    typedef struct packed {
        logic [7:0]  cu_id;
        logic [7:0]  command;
        logic [15:0] size;
        logic [31:0] address;
    } command_buffer_line_t;

    function automatic logic [7:0] control_id_of(input cmd_arb_req_t req);
        return CMD_ARB_CONTROL_ID[req];
    endfunction

endpackage

// File: rtl/round_robin_priority_select.sv
// rtl/round_robin_priority_select.sv - combinational round-robin pick starting at ptr
module round_robin_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int               cand_int;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_int  = 0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_int = int'(ptr) + i;
            if (cand_int >= NUM_REQ) begin
                cand_int = cand_int - NUM_REQ;
            end
            cand = IDX_W'(cand_int);
            if (!grant_any && valid[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cu_command_request_arbiter.sv
// rtl/cu_command_request_arbiter.sv - credit-limited round-robin command arbiter for one CU
// Optional per-requester grant counters: CU_CMD_ARB_STATS_EN
module cu_command_request_arbiter
    import globals_cu_pkg::*;
#(
    parameter int NUM_REQ     = NUM_CU_CMD_REQ,
    parameter int CMD_CREDITS = CU_CMD_CREDITS,
    parameter int CREDIT_W    = CU_CMD_CREDIT_W
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enabled,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  command_buffer_line_t [NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               cmd_out_valid,
    output command_buffer_line_t               cmd_out,
    input  logic                               cmd_out_ready,
    input  logic                               rsp_valid,
    output logic [CREDIT_W-1:0]                credits_avail,
    output logic                               busy,
    output logic                               credit_err,
    output logic [NUM_REQ-1:0][31:0]           stats_grants
);

    localparam int                  IDX_W       = $clog2(NUM_REQ);
    localparam logic [CREDIT_W-1:0] CREDITS_MAX = CREDIT_W'(CMD_CREDITS);

    cmd_arb_state_t       state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_idx;
    logic [NUM_REQ-1:0]   rr_grant;
    logic                 rr_any;
    logic                 grant_ok;
    logic                 grant_fire;
    logic                 credits_full;
    command_buffer_line_t granted_cmd;

    round_robin_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .grant_any (rr_any)
    );

    // The output slot can take a new command when empty or when it drains this cycle.
    assign credits_full = (credits_avail == CREDITS_MAX);
    assign grant_ok     = (state == S_RUN) && (credits_avail != '0)
                          && (!cmd_out_valid || cmd_out_ready);
    assign grant_fire   = grant_ok && rr_any;
    assign req_ready    = grant_ok ? rr_grant : '0;
    assign busy         = (state != S_IDLE) || cmd_out_valid;

    always_comb begin
        granted_cmd       = req_cmd[rr_idx];
        granted_cmd.cu_id = control_id_of(cmd_arb_req_t'(rr_idx));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (enabled) state <= S_RUN;
                S_RUN:   if (!enabled) state <= S_DRAIN;
                S_DRAIN: begin
                    if (enabled) begin
                        state <= S_RUN;
                    end else if (!cmd_out_valid && credits_full) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_out_valid <= 1'b0;
            cmd_out       <= '0;
            rr_ptr        <= '0;
        end else if (grant_fire) begin
            cmd_out_valid <= 1'b1;
            cmd_out       <= granted_cmd;
            rr_ptr        <= (rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
        end else if (cmd_out_ready) begin
            cmd_out_valid <= 1'b0;
        end
    end

    // A response with nothing outstanding is a protocol error; the count never exceeds the pool.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits_avail <= CREDITS_MAX;
            credit_err    <= 1'b0;
        end else begin
            if (rsp_valid && credits_full) begin
                credit_err <= 1'b1;
            end
            if (grant_fire && !rsp_valid) begin
                credits_avail <= credits_avail - 1'b1;
            end else if (!grant_fire && rsp_valid && !credits_full) begin
                credits_avail <= credits_avail + 1'b1;
            end
        end
    end

`ifdef CU_CMD_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stats_grants <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_fire && (rr_idx == IDX_W'(i))) begin
                    stats_grants[i] <= stats_grants[i] + 32'd1;
                end
            end
        end
    end
`else
    assign stats_grants = '0;
`endif

endmodule

// File: tb/tb_cu_command_request_arbiter.sv
// tb/tb_cu_command_request_arbiter.sv - randomized model-checked bench for the CU command arbiter
module tb_cu_command_request_arbiter;
    import globals_cu_pkg::*;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic                       enabled = 1'b0;
    logic [3:0]                 req_valid = 4'h0;
    command_buffer_line_t [3:0] req_cmd;
    logic [3:0]                 req_ready;
    logic                       cmd_out_valid;
    command_buffer_line_t       cmd_out;
    logic                       cmd_out_ready = 1'b0;
    logic                       rsp_valid = 1'b0;
    logic [5:0]                 credits_avail;
    logic                       busy;
    logic                       credit_err;
    logic [3:0][31:0]           stats_grants;

    always #5 clock = ~clock;

    cu_command_request_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .enabled       (enabled),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .cmd_out_valid (cmd_out_valid),
        .cmd_out       (cmd_out),
        .cmd_out_ready (cmd_out_ready),
        .rsp_valid     (rsp_valid),
        .credits_avail (credits_avail),
        .busy          (busy),
        .credit_err    (credit_err),
        .stats_grants  (stats_grants)
    );

    localparam logic [7:0] ID_TAB [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 drain; m_ptr is where the next search starts.
    int          m_state;
    int          m_cred;
    bit          m_err;
    int          m_ptr;
    bit          m_ov;
    logic [63:0] m_out;
    logic [31:0] m_stats [4];

    logic [3:0]           obs_rr;
    logic                 obs_busy;
    logic                 obs_err;
    logic [5:0]           obs_cred;
    command_buffer_line_t obs_out;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cred  = 32;
        m_err   = 1'b0;
        m_ptr   = 0;
        m_ov    = 1'b0;
        m_out   = '0;
        for (int k = 0; k < 4; k++) m_stats[k] = '0;
    endtask

    task automatic rand_cmds();
        for (int k = 0; k < 4; k++) req_cmd[k] = {$urandom, $urandom};
    endtask

    task automatic hw_reset();
        reset         = 1'b1;
        enabled       = 1'b0;
        req_valid     = 4'h0;
        cmd_out_ready = 1'b0;
        rsp_valid     = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: compare at the falling edge, advance the model, return 1 unit after the rising edge.
    task automatic step();
        int         g;
        int         nstate;
        bit         ok;
        logic [3:0] exp_rr;
        logic [31:0] exp_stat;
        g      = -1;
        exp_rr = 4'h0;
        @(negedge clock);
        ok = (m_state == 1) && (m_cred > 0) && (!m_ov || cmd_out_ready);
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_rr[g] = 1'b1;

        chk("req_ready", req_ready, exp_rr);
        chk("cmd_out_valid", cmd_out_valid, m_ov);
        if (m_ov) chk("cmd_out", cmd_out, m_out);
        chk("credits_avail", credits_avail, m_cred);
        chk("busy", busy, (m_state != 0) || m_ov);
        chk("credit_err", credit_err, m_err);
        for (int k = 0; k < 4; k++) begin
`ifdef CU_CMD_ARB_STATS_EN
            exp_stat = m_stats[k];
`else
            exp_stat = '0;
`endif
            chk("stats_grants", stats_grants[k], exp_stat);
        end

        obs_rr   = req_ready;
        obs_busy = busy;
        obs_err  = credit_err;
        obs_cred = credits_avail;
        obs_out  = cmd_out;

        nstate = m_state;
        case (m_state)
            0: if (enabled) nstate = 1;
            1: if (!enabled) nstate = 2;
            default: begin
                if (enabled) nstate = 1;
                else if (!m_ov && m_cred == 32) nstate = 0;
            end
        endcase
        if (rsp_valid && m_cred == 32) m_err = 1'b1;
        if (g >= 0 && !rsp_valid) m_cred = m_cred - 1;
        else if (g < 0 && rsp_valid && m_cred < 32) m_cred = m_cred + 1;
        if (g >= 0) begin
            m_ov       = 1'b1;
            m_out      = {ID_TAB[g], req_cmd[g][55:0]};
            m_ptr      = (g + 1) % 4;
            m_stats[g] = m_stats[g] + 32'd1;
        end else if (cmd_out_ready) begin
            m_ov = 1'b0;
        end
        m_state = nstate;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0]           seq_rr [6];
        logic [7:0]           seq_id [6];
        logic [3:0]           exp_seq_rr [5];
        logic [7:0]           exp_seq_id [5];
        int                   ngr;
        command_buffer_line_t held;

        exp_seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_seq_id = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        rand_cmds();

        // Reset values and the basic rotation.
        hw_reset();
        chk("reset_credits", credits_avail, 32);
        chk("reset_cmd_out_valid", cmd_out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_credit_err", credit_err, 0);
        chk("reset_req_ready", req_ready, 0);
        enabled       = 1'b1;
        req_valid     = 4'hF;
        cmd_out_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            seq_rr[i] = obs_rr;
            seq_id[i] = obs_out.cu_id;
        end
        for (int i = 0; i < 5; i++) begin
            chk("rr_sequence", seq_rr[i], exp_seq_rr[i]);
            chk("cu_id_sequence", seq_id[i+1], exp_seq_id[i]);
        end

        // Credit exhaustion and a single returned credit.
        hw_reset();
        enabled       = 1'b1;
        req_valid     = 4'hF;
        cmd_out_ready = 1'b1;
        ngr = 0;
        repeat (40) begin
            step();
            if (obs_rr != 0) ngr++;
        end
        chk("credit_limit_grants", ngr, 32);
        chk("credits_zero", obs_cred, 0);
        chk("ready_at_zero", obs_rr, 0);
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        ngr = 0;
        repeat (5) begin
            step();
            if (obs_rr != 0) ngr++;
        end
        chk("one_more_grant", ngr, 1);

        // Back-pressure hold, drain-and-grant, grant with simultaneous response.
        hw_reset();
        enabled       = 1'b1;
        req_valid     = 4'hF;
        cmd_out_ready = 1'b1;
        step();
        step();
        cmd_out_ready = 1'b0;
        step();
        held = obs_out;
        chk("hold_first_id", held.cu_id, 8'h10);
        repeat (5) begin
            rand_cmds();
            step();
            chk("hold_stable", obs_out, held);
            chk("hold_no_grant", obs_rr, 0);
        end
        cmd_out_ready = 1'b1;
        step();
        chk("drain_and_grant", obs_rr, 4'b0010);
        chk("drain_value", obs_out, held);
        rsp_valid = 1'b1;
        step();
        chk("credits_before_grant_rsp", obs_cred, 30);
        rsp_valid = 1'b0;
        step();
        chk("credits_grant_rsp_unchanged", obs_cred, 30);

        // Spurious response with a full pool.
        hw_reset();
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        step();
        chk("credit_err_set", obs_err, 1);
        chk("credits_stay_full", obs_cred, 32);
        repeat (3) step();
        chk("credit_err_sticky", obs_err, 1);

        // Drain with three outstanding commands.
        hw_reset();
        enabled       = 1'b1;
        req_valid     = 4'hF;
        cmd_out_ready = 1'b1;
        step();
        repeat (3) step();
        req_valid = 4'h0;
        enabled   = 1'b0;
        step();
        step();
        chk("drain_busy", obs_busy, 1);
        chk("drain_credits", obs_cred, 29);
        rsp_valid = 1'b1;
        repeat (3) step();
        rsp_valid = 1'b0;
        step();
        step();
        chk("drain_idle_not_busy", obs_busy, 0);

        // Asynchronous reset in the middle of a burst.
        hw_reset();
        enabled       = 1'b1;
        req_valid     = 4'hF;
        cmd_out_ready = 1'b1;
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", cmd_out_valid, 0);
        chk("async_reset_credits", credits_avail, 32);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_stats", |stats_grants, 0);
        enabled   = 1'b0;
        req_valid = 4'h0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        hw_reset();
        enabled = 1'b1;
        repeat (3000) begin
            rand_cmds();
            req_valid     = 4'($urandom_range(0, 15));
            cmd_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) enabled = ~enabled;
            if (m_cred < 32) rsp_valid = ($urandom_range(0, 9) < 4);
            else             rsp_valid = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
